// File: rtl/bus_ram_if.sv
// Control handshake between a bus master and bus_ram.
// The tri-state data bus is a plain inout on bus_ram so it resolves at the instantiating level.
interface bus_ram_if;
    logic enable;
    logic rw;
    logic last;
    logic busy;
    logic err;

    modport master (output enable, rw, last, input busy, err);
    modport slave  (input enable, rw, last, output busy, err);
endinterface

// File: rtl/bus_ram.sv
// Word RAM on a shared tri-state bus: little-endian address beats, then data beats.
// Define BUS_RAM_BURST_EN to stream data beats at incrementing addresses until last=1.
module bus_ram #(
    parameter int BITW   = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic           clock,
    input  logic           n_reset,
    bus_ram_if.slave       ctl,
    inout  wire [BITW-1:0] bus
);
    localparam int ABEATS = (ADDR_W + BITW - 1) / BITW;
    localparam int ABUF_W = ABEATS * BITW;
    localparam int CNT_W  = $clog2(ABEATS + 1);
`ifdef BUS_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ADDR, READ, WRITE} state_t;

    state_t            state;
    logic [ABUF_W-1:0] abuf;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              mode;
    logic              err_q;
    logic              oe;
    logic [BITW-1:0]   rdata;
    logic              in_range;
    logic              rd_beat;
    logic              wr_beat;
    logic              data_beat;
    logic              done;
    logic [BITW-1:0]   mem [DEPTH];

    // Address beats past ADDR_W are captured but never used.
    assign addr      = abuf[ADDR_W-1:0];
    assign in_range  = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    assign addr_nxt  = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
    assign rd_beat   = (state == READ)  && ctl.enable;
    assign wr_beat   = (state == WRITE) && ctl.enable && ctl.rw;
    assign data_beat = rd_beat || wr_beat;
    assign done      = !BURST || ctl.last;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            abuf  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            err_q <= 1'b0;
            oe    <= 1'b0;
        end else begin
            err_q <= data_beat && !in_range;
            oe    <= rd_beat;
            case (state)
                IDLE: if (ctl.enable) begin
                    abuf <= ABUF_W'(bus);
                    mode <= ctl.rw;
                    cnt  <= CNT_W'(1);
                    if (ABEATS == 1) state <= ctl.rw ? WRITE : READ;
                    else             state <= ADDR;
                end
                ADDR: if (ctl.enable) begin
                    abuf[int'(cnt)*BITW +: BITW] <= bus;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ABEATS - 1)) state <= mode ? WRITE : READ;
                end
                READ, WRITE: begin
                    // rw dropping during a write beat aborts without touching memory.
                    if (state == WRITE && ctl.enable && !ctl.rw) begin
                        state <= IDLE;
                    end else if (data_beat) begin
                        if (done) state <= IDLE;
                        else      abuf  <= ABUF_W'(addr_nxt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; out-of-range writes drop and reads return zero.
    always_ff @(posedge clock) begin
        if (wr_beat && in_range) mem[addr] <= bus;
        if (rd_beat) rdata <= in_range ? mem[addr] : '0;
    end

    assign bus      = oe ? rdata : 'z;
    assign ctl.busy = (state != IDLE);
    assign ctl.err  = err_q;
endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: a default instance and a DEPTH=1000 instance see the same stimulus.
// The bench parks 0x00 on the bus whenever the RAM must not drive, so any stray drive disturbs it.
module tb_bus_ram;
    logic clock = 1'b0;
    logic n_reset;
    logic en, rw, last, drv_en;
    logic [7:0] drv;
    wire  [7:0] bus_a, bus_b;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    bus_ram_if ifa ();
    bus_ram_if ifb ();
    assign ifa.enable = en;
    assign ifa.rw     = rw;
    assign ifa.last   = last;
    assign ifb.enable = en;
    assign ifb.rw     = rw;
    assign ifb.last   = last;
    assign bus_a = drv_en ? drv : 'z;
    assign bus_b = drv_en ? drv : 'z;

    bus_ram dut_a (.clock(clock), .n_reset(n_reset), .ctl(ifa), .bus(bus_a));
    bus_ram #(.BITW(8), .ADDR_W(10), .DEPTH(1000)) dut_b (
        .clock(clock), .n_reset(n_reset), .ctl(ifb), .bus(bus_b));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic e, input logic r, input logic l, input logic [7:0] d);
        en = e; rw = r; last = l; drv = d; drv_en = 1'b1;
        tick();
    endtask

    task automatic idle();
        en = 1'b0; drv = 8'h00; drv_en = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b1; en = 1'b0; rw = 1'b0; last = 1'b1; drv = 8'h00; drv_en = 1'b1;
        #1 n_reset = 1'b0;
        #12;
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_a: got %b want 0", ifa.busy); end
        total++; if (ifb.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_b: got %b want 0", ifb.busy); end
        total++; if (ifa.err !== 1'b0) begin bad++; $display("FAIL rst_err_a: got %b want 0", ifa.err); end
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL rst_float: got %h want 00", bus_a); end
        @(negedge clock) n_reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        beat(1, 1, 1, 8'h34);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL wr_busy1: got %b want 1", ifa.busy); end
        beat(1, 1, 1, 8'h01);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL wr_busy2: got %b want 1", ifa.busy); end
        beat(1, 1, 1, 8'hA5);
        idle();
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL wr_busy3: got %b want 0", ifa.busy); end
        total++; if (ifa.err !== 1'b0 || ifb.err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b%b want 00", ifa.err, ifb.err); end
        tick();
    endtask

    task automatic test_read();
        beat(1, 0, 1, 8'h34);
        beat(1, 0, 1, 8'h01);
        en = 1'b1; drv = 8'h00;
        #1;
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL rd_float_before: got %h want 00", bus_a); end
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'hA5) begin bad++; $display("FAIL rd_data_a: got %h want a5", bus_a); end
        total++; if (bus_b !== 8'hA5) begin bad++; $display("FAIL rd_data_b: got %h want a5", bus_b); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rd_busy: got %b want 0", ifa.busy); end
        tick();
        idle();
        #1;
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL rd_float_after: got %h want 00", bus_a); end
    endtask

    task automatic test_range();
        beat(1, 1, 1, 8'hE8);
        beat(1, 1, 1, 8'h03);
        beat(1, 1, 1, 8'h77);
        idle();
        total++; if (ifb.err !== 1'b1) begin bad++; $display("FAIL oor_wr_err_b: got %b want 1", ifb.err); end
        total++; if (ifa.err !== 1'b0) begin bad++; $display("FAIL oor_wr_err_a: got %b want 0", ifa.err); end
        tick();
        total++; if (ifb.err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse: got %b want 0", ifb.err); end
        beat(1, 0, 1, 8'hE8);
        beat(1, 0, 1, 8'h03);
        en = 1'b1; drv = 8'h00;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'h77) begin bad++; $display("FAIL oor_rd_a: got %h want 77", bus_a); end
        total++; if (bus_b !== 8'h00) begin bad++; $display("FAIL oor_rd_b: got %h want 00", bus_b); end
        total++; if (ifb.err !== 1'b1) begin bad++; $display("FAIL oor_rd_err_b: got %b want 1", ifb.err); end
        tick();
        idle();
        total++; if (ifb.err !== 1'b0) begin bad++; $display("FAIL oor_rd_err_clr: got %b want 0", ifb.err); end
    endtask

    task automatic test_abort();
        beat(1, 1, 1, 8'h20);
        beat(1, 1, 1, 8'h00);
        beat(1, 1, 1, 8'h5A);
        beat(1, 1, 1, 8'h20);
        beat(1, 1, 1, 8'h00);
        beat(1, 0, 1, 8'hFF);
        idle();
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", ifa.busy); end
        total++; if (ifa.err !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", ifa.err); end
        beat(1, 0, 1, 8'h20);
        beat(1, 0, 1, 8'h00);
        en = 1'b1; drv = 8'h00;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'h5A) begin bad++; $display("FAIL abort_keep: got %h want 5a", bus_a); end
        tick();
        idle();
    endtask

    task automatic test_hold();
        beat(1, 1, 1, 8'h40);
        beat(0, 1, 1, 8'h99);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL hold_addr_busy: got %b want 1", ifa.busy); end
        beat(1, 1, 1, 8'h00);
        beat(0, 1, 1, 8'h77);
        beat(0, 0, 1, 8'h66);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL hold_wr_busy: got %b want 1", ifa.busy); end
        beat(1, 1, 1, 8'h3C);
        beat(1, 0, 1, 8'h40);
        beat(1, 0, 1, 8'h00);
        beat(0, 0, 1, 8'h00);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL hold_rd_busy: got %b want 1", ifa.busy); end
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL hold_rd_float: got %h want 00", bus_a); end
        en = 1'b1;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'h3C) begin bad++; $display("FAIL hold_data: got %h want 3c", bus_a); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        beat(1, 0, 1, 8'h34);
        beat(1, 0, 1, 8'h01);
        en = 1'b1; drv = 8'h00;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'hA5) begin bad++; $display("FAIL mid_pre: got %h want a5", bus_a); end
        n_reset = 1'b0;
        drv_en = 1'b1; drv = 8'h00;
        #1;
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL mid_float: got %h want 00", bus_a); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", ifa.busy); end
        @(negedge clock) n_reset = 1'b1;
        tick();
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL mid_no_drive: got %h want 00", bus_a); end
        beat(1, 0, 1, 8'h34);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL mid_addr_beat: got %b want 1", ifa.busy); end
        beat(1, 0, 1, 8'h01);
        en = 1'b1; drv = 8'h00;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'hA5) begin bad++; $display("FAIL mid_reread: got %h want a5", bus_a); end
        tick();
        idle();
    endtask

`ifdef BUS_RAM_BURST_EN
    task automatic test_burst();
        beat(1, 1, 0, 8'hFE);
        beat(1, 1, 0, 8'h03);
        beat(1, 1, 0, 8'h11);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL bw_busy1: got %b want 1", ifa.busy); end
        beat(1, 1, 0, 8'h22);
        beat(1, 1, 1, 8'h33);
        idle();
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL bw_busy3: got %b want 0", ifa.busy); end
        beat(1, 0, 0, 8'hFE);
        beat(1, 0, 0, 8'h03);
        en = 1'b1; last = 1'b0; drv = 8'h00;
        tick();
        drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'h11) begin bad++; $display("FAIL br_d0: got %h want 11", bus_a); end
        tick();
        total++; if (bus_a !== 8'h22) begin bad++; $display("FAIL br_d1: got %h want 22", bus_a); end
        last = 1'b1;
        tick();
        en = 1'b0;
        total++; if (bus_a !== 8'h33) begin bad++; $display("FAIL br_d2: got %h want 33", bus_a); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL br_busy: got %b want 0", ifa.busy); end
        tick();
        idle();
        #1;
        total++; if (bus_a !== 8'h00) begin bad++; $display("FAIL br_float: got %h want 00", bus_a); end
    endtask
`else
    task automatic test_no_burst();
        beat(1, 1, 0, 8'h50);
        beat(1, 1, 0, 8'h00);
        beat(1, 1, 0, 8'h6B);
        idle();
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL nb_wr_single: got %b want 0", ifa.busy); end
        beat(1, 0, 0, 8'h50);
        beat(1, 0, 0, 8'h00);
        en = 1'b1; drv = 8'h00;
        tick();
        en = 1'b0; drv_en = 1'b0;
        #1;
        total++; if (bus_a !== 8'h6B) begin bad++; $display("FAIL nb_rd_data: got %h want 6b", bus_a); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL nb_rd_single: got %b want 0", ifa.busy); end
        tick();
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_range();
        test_abort();
        test_hold();
        test_reset_mid();
`ifdef BUS_RAM_BURST_EN
        test_burst();
`else
        test_no_burst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
